// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to a keyboard or mouse
// over the open-drain clk/data pair, then checks the device ACK bit.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   tx_data[7:0], tx_start   command byte and one-cycle request (taken when idle)
//   tx_busy, tx_done, tx_err transfer status (tx_err valid with tx_done)
//   ps2_clk_in, ps2_data_in  asynchronous pin levels
//   ps2_clk_oe, ps2_data_oe  1 = pull the line low (registered)
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FRM_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t             state, state_next;
    logic [INH_W-1:0]   inh_cnt, inh_cnt_next;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_next;
    logic [3:0]         bit_cnt, bit_cnt_next;
    logic [FRM_W-1:0]   shreg, shreg_next;
    logic               clk_oe_next, data_oe_next;
    logic               done_next, err_next, busy_next;

    // Pin synchronisers; clk keeps one extra stage for falling-edge detection.
    logic [2:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_s, data_s, clk_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    assign clk_s    = clk_sync[1];
    assign data_s   = data_sync[1];
    assign clk_fall = clk_sync[2] & ~clk_sync[1];

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            tx_busy     <= 1'b0;
        end else begin
            state       <= state_next;
            inh_cnt     <= inh_cnt_next;
            tmo_cnt     <= tmo_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shreg       <= shreg_next;
            ps2_clk_oe  <= clk_oe_next;
            ps2_data_oe <= data_oe_next;
            tx_done     <= done_next;
            tx_err      <= err_next;
            tx_busy     <= busy_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next   = state;
        inh_cnt_next = inh_cnt;
        tmo_cnt_next = tmo_cnt;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        clk_oe_next  = ps2_clk_oe;
        data_oe_next = ps2_data_oe;
        done_next    = 1'b0;
        err_next     = tx_err;
        busy_next    = tx_busy;

        case (state)
            IDLE: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                // busy stays up through the tx_done cycle, so a start there is ignored
                if (tx_done) begin
                    busy_next = 1'b0;
                end else if (tx_start && !tx_busy) begin
                    shreg_next   = {1'b1, ~^tx_data, tx_data};
                    err_next     = 1'b0;
                    busy_next    = 1'b1;
                    inh_cnt_next = '0;
                    clk_oe_next  = 1'b1;
                    state_next   = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_oe_next = 1'b1;
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_next = 1'b1;
                    state_next   = REQ;
                end else begin
                    inh_cnt_next = inh_cnt + INH_W'(1);
                end
            end
            REQ: begin
                // release clk while holding data low: start bit
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b1;
                bit_cnt_next = '0;
                tmo_cnt_next = '0;
                state_next   = BITS;
            end
            BITS: begin
                if (clk_fall) begin
                    // ones shifted in make the tenth edge release data (stop bit)
                    data_oe_next = ~shreg[0];
                    shreg_next   = {1'b1, shreg[FRM_W-1:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_next = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    err_next   = data_s;
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
            end
        endcase

        // Timeout covers everything after clk release; it overrides normal completion.
        if (state == BITS || state == ACK || state == WAIT_IDLE) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                err_next     = 1'b1;
                done_next    = 1'b1;
                state_next   = IDLE;
            end else begin
                tmo_cnt_next = tmo_cnt + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model on the open-drain lines.
module tb_ps2_host_tx;

    localparam int unsigned INH = 10;
    localparam int unsigned TMO = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Wired-AND open-drain lines with pull-ups.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Request a transfer and check inhibit, request and clk release timing.
    task automatic start_tx(input logic [7:0] d);
        bit ok;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h5A;
        check("busy_after_accept", 32'(tx_busy), 32'd1);
        check("err_cleared_on_accept", 32'(tx_err), 32'd0);
        ok = 1'b1;
        for (int i = 0; i < int'(INH); i++) begin
            if (i > 0) @(negedge clk);
            if (!(ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0)) ok = 1'b0;
        end
        check("inhibit_window", 32'(ok), 32'd1);
        @(negedge clk);
        check("req_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check("req_data_oe", 32'(ps2_data_oe), 32'd1);
        @(negedge clk);
        check("clk_released", 32'(ps2_clk_oe), 32'd0);
        check("start_bit_held", 32'(ps2_data_oe), 32'd1);
    endtask

    // Device: samples data on each rising edge, 240 ns clock period.
    // inject_at: pulse tx_start with 8'hAA after that falling edge.
    // rst_at: pulse rst after that falling edge and abort the frame.
    task automatic dev_frame(input bit ack, input int rst_at, input int inject_at,
                             output logic [10:0] samp);
        samp    = '0;
        samp[0] = ps2_data_in;
        for (int k = 1; k <= 10; k++) begin
            #120 dev_clk_low = 1'b1;
            if (k == inject_at) begin
                #5 tx_data = 8'hAA;
                tx_start = 1'b1;
                #20 tx_start = 1'b0;
                #95;
            end else if (k == rst_at) begin
                #85 rst = 1'b1;
                #15;
                check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
                check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
                check("rst_busy", 32'(tx_busy), 32'd0);
                #5 rst = 1'b0;
                #15 dev_clk_low = 1'b0;
                return;
            end else begin
                #120;
            end
            dev_clk_low = 1'b0;
            samp[k] = ps2_data_in;
        end
        dev_data_low = ack;
        #120 dev_clk_low = 1'b1;
        #120 dev_clk_low = 1'b0;
        if (ack) begin
            #120 dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cycles++;
            if (tx_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic finish_tx(input logic exp_err);
        int cyc;
        bit seen;
        wait_done(cyc, seen);
        check("err_at_done", 32'(tx_err), 32'(exp_err));
        check("clk_oe_at_done", 32'(ps2_clk_oe), 32'd0);
        check("data_oe_at_done", 32'(ps2_data_oe), 32'd0);
        check("busy_at_done", 32'(tx_busy), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(tx_done), 32'd0);
        check("busy_after_done", 32'(tx_busy), 32'd0);
        check("err_held", 32'(tx_err), 32'(exp_err));
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [10:0] samp;
        int cyc;
        int d0;
        bit seen;

        rst          = 1'b1;
        tx_start     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        check("reset_err", 32'(tx_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8'hED: start 0, data LSB first, parity 1, stop 1
        start_tx(8'hED);
        dev_frame(1'b1, 0, 0, samp);
        check("frame_ed", 32'(samp), 32'h7DA);
        finish_tx(1'b0);

        // 8'h01: parity 0
        start_tx(8'h01);
        dev_frame(1'b1, 0, 0, samp);
        check("frame_01", 32'(samp), 32'h402);
        check("parity_01", 32'(samp[9]), 32'd0);
        finish_tx(1'b0);

        // 8'h00: parity 1
        start_tx(8'h00);
        dev_frame(1'b1, 0, 0, samp);
        check("frame_00", 32'(samp), 32'h600);
        check("parity_00", 32'(samp[9]), 32'd1);
        finish_tx(1'b0);

        // Device leaves data high on the ACK edge
        start_tx(8'hFF);
        dev_frame(1'b0, 0, 0, samp);
        check("frame_ff", 32'(samp), 32'h7FE);
        finish_tx(1'b1);

        // Device never clocks: timeout 2000 cycles after clk release
        start_tx(8'h3C);
        wait_done(cyc, seen);
        check("timeout_cycles", 32'(cyc), 32'd2000);
        check("timeout_err", 32'(tx_err), 32'd1);
        check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
        @(negedge clk);
        check("timeout_busy_after", 32'(tx_busy), 32'd0);
        repeat (5) @(negedge clk);

        // Second request with 8'hAA mid-frame is ignored
        d0 = done_cnt;
        start_tx(8'hED);
        dev_frame(1'b1, 0, 3, samp);
        check("frame_ed_ignore_aa", 32'(samp), 32'h7DA);
        finish_tx(1'b0);
        repeat (50) @(negedge clk);
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("no_restart_busy", 32'(tx_busy), 32'd0);

        // Reset during bit 4, then a clean 8'hF4 transfer
        d0 = done_cnt;
        start_tx(8'h12);
        dev_frame(1'b1, 4, 0, samp);
        repeat (100) @(negedge clk);
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_idle_busy", 32'(tx_busy), 32'd0);
        check("rst_idle_clk_oe", 32'(ps2_clk_oe), 32'd0);
        start_tx(8'hF4);
        dev_frame(1'b1, 0, 0, samp);
        check("frame_f4", 32'(samp), 32'h5E8);
        finish_tx(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
